// File: rtl/sym_tx_pkg.sv
// Shared types for the sym_tx symbol transmitter and its optional reference FSM.
// The reference FSM is built only when SYM_TX_CHECK_EN is defined.
package sym_tx_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_e;

    // Reference FSM state numbers; the output equals the state number except TRESDOIS.
    localparam logic [2:0] ZERO     = 3'd0;
    localparam logic [2:0] UM       = 3'd1;
    localparam logic [2:0] DOIS     = 3'd2;
    localparam logic [2:0] TRES     = 3'd3;
    localparam logic [2:0] QUATRO   = 3'd4;
    localparam logic [2:0] CINCO    = 3'd5;
    localparam logic [2:0] SEIS     = 3'd6;
    localparam logic [2:0] TRESDOIS = 3'd7;

    function automatic logic [2:0] model_out(input logic [2:0] st);
        return (st == TRESDOIS) ? TRES : st;
    endfunction

endpackage

// File: rtl/sym_tx_model.sv
// Reference 2-bit-input FSM that checks the consumer's saida against the driven a.
// Instantiated by sym_tx only when SYM_TX_CHECK_EN is defined.
module sym_tx_model
    import sym_tx_pkg::*;
(
    input  logic       clk,
    input  logic       res,
    input  logic [1:0] a,
    input  logic [2:0] saida_in,
    output logic       mismatch,
    output logic [7:0] err_cnt
);

    logic [2:0]  st_q, st_d;
    logic        mismatch_q, mismatch_d;
    logic [7:0]  err_q, err_d;
    logic [11:0] row;

    always_comb begin
        // Each row packs the next states for a = 3,2,1,0 from MSB to LSB.
        case (st_q)
            ZERO:    row = {CINCO, UM,       TRESDOIS, UM};
            UM:      row = {CINCO, TRESDOIS, TRESDOIS, DOIS};
            DOIS:    row = {CINCO, TRES,     QUATRO,   ZERO};
            TRES:    row = {CINCO, UM,       DOIS,     ZERO};
            QUATRO:  row = {CINCO, UM,       TRESDOIS, ZERO};
            CINCO:   row = {SEIS,  UM,       TRES,     ZERO};
            SEIS:    row = {TRES,  UM,       TRES,     ZERO};
            default: row = {CINCO, DOIS,     DOIS,     ZERO};
        endcase
        st_d       = row[3*a +: 3];
        mismatch_d = mismatch_q;
        err_d      = err_q;
        if (saida_in != model_out(st_q)) begin
            mismatch_d = 1'b1;
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            st_q       <= ZERO;
            mismatch_q <= 1'b0;
            err_q      <= 8'd0;
        end else begin
            st_q       <= st_d;
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
        end
    end

    assign mismatch = mismatch_q;
    assign err_cnt  = err_q;

endmodule

// File: rtl/sym_tx.sv
// Drives a packed word of 2-bit symbols MSB-first onto a[1:0], each held for a programmable count.
// Define SYM_TX_CHECK_EN to add the saida reference checker (saida_in, mismatch, err_cnt).
module sym_tx
    import sym_tx_pkg::*;
#(
    parameter  int NSYM   = 9,
    parameter  int HOLD_W = 4,
    localparam int LEN_W  = $clog2(NSYM + 1)
) (
    input  logic              clk,
    input  logic              res,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [2*NSYM-1:0] load_data,
    input  logic [LEN_W-1:0]  load_len,
    input  logic [HOLD_W-1:0] load_hold,
    input  logic              abort,
    output logic [1:0]        a,
    output logic              a_valid,
    output logic              busy,
`ifdef SYM_TX_CHECK_EN
    input  logic [2:0]        saida_in,
    output logic              mismatch,
    output logic [7:0]        err_cnt,
`endif
    output logic              done
);

    tx_state_e         state_q, state_d;
    logic [2*NSYM-1:0] shift_q, shift_d;
    logic [LEN_W-1:0]  left_q, left_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HOLD_W-1:0] hcnt_q, hcnt_d;
    logic [1:0]        a_q, a_d;
    logic              a_valid_q, a_valid_d;
    logic              done_q, done_d;

    logic              accept;
    logic [LEN_W-1:0]  len_c;
    logic [HOLD_W-1:0] hold_c;

    always_comb begin
        accept = load_valid && (state_q == ST_IDLE);
        len_c  = (load_len > LEN_W'(NSYM)) ? LEN_W'(NSYM) : load_len;
        hold_c = (load_hold == '0) ? HOLD_W'(1) : load_hold;

        // NOTE: every _d takes its _q value first so no path through this block can infer a latch.
        state_d   = state_q;
        shift_d   = shift_q;
        left_d    = left_q;
        hold_d    = hold_q;
        hcnt_d    = hcnt_q;
        a_d       = a_q;
        a_valid_d = a_valid_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept && !abort) begin
                    if (len_c == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = ST_SEND;
                        a_d       = load_data[2*NSYM-1 -: 2];
                        a_valid_d = 1'b1;
                        shift_d   = load_data << 2;
                        left_d    = len_c - LEN_W'(1);
                        hold_d    = hold_c;
                        hcnt_d    = hold_c - HOLD_W'(1);
                    end
                end
            end
            ST_SEND: begin
                // hcnt counts the cycles still to go after the current one; left counts symbols after this one.
                if (abort) begin
                    state_d   = ST_IDLE;
                    a_d       = 2'b00;
                    a_valid_d = 1'b0;
                end else if (hcnt_q == '0) begin
                    if (left_q == '0) begin
                        state_d   = ST_IDLE;
                        a_d       = 2'b00;
                        a_valid_d = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        a_d     = shift_q[2*NSYM-1 -: 2];
                        shift_d = shift_q << 2;
                        left_d  = left_q - LEN_W'(1);
                        hcnt_d  = hold_q - HOLD_W'(1);
                    end
                end else begin
                    hcnt_d = hcnt_q - HOLD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state updates use <= so every flop samples the pre-edge values computed above.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            left_q    <= '0;
            hold_q    <= '0;
            hcnt_q    <= '0;
            a_q       <= 2'b00;
            a_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            left_q    <= left_d;
            hold_q    <= hold_d;
            hcnt_q    <= hcnt_d;
            a_q       <= a_d;
            a_valid_q <= a_valid_d;
            done_q    <= done_d;
        end
    end

    assign a          = a_q;
    assign a_valid    = a_valid_q;
    assign done       = done_q;
    assign busy       = (state_q == ST_SEND);
    assign load_ready = (state_q == ST_IDLE);

`ifdef SYM_TX_CHECK_EN
    sym_tx_model u_model (
        .clk      (clk),
        .res      (res),
        .a        (a_q),
        .saida_in (saida_in),
        .mismatch (mismatch),
        .err_cnt  (err_cnt)
    );
`endif

endmodule

// File: tb/tb_sym_tx.sv
// Scoreboard bench for sym_tx: the stimulus queues expected (cycle, symbol) and done events,
// and a negedge monitor pops and compares them. With SYM_TX_CHECK_EN the saida checker is exercised too.
module tb_sym_tx;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [17:0] load_data = '0;
    logic [3:0]  load_len = '0;
    logic [3:0]  load_hold = '0;
    logic        abort = 1'b0;
    logic [1:0]  a;
    logic        a_valid;
    logic        busy;
    logic        done;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        int         cyc;
        logic [1:0] sym;
    } exp_t;

    exp_t exp_sym[$];
    int   exp_done[$];

`ifdef SYM_TX_CHECK_EN
    logic [2:0] saida_in;
    logic       mismatch;
    logic [7:0] err_cnt;
    logic       force_bad = 1'b0;
    logic [2:0] ref_st;

    // Consumer FSM from the state table: rows S0..S7, columns a = 0..3.
    localparam logic [2:0] REF_TAB [8][4] = '{
        '{3'd1, 3'd7, 3'd1, 3'd5},
        '{3'd2, 3'd7, 3'd7, 3'd5},
        '{3'd0, 3'd4, 3'd3, 3'd5},
        '{3'd0, 3'd2, 3'd1, 3'd5},
        '{3'd0, 3'd7, 3'd1, 3'd5},
        '{3'd0, 3'd3, 3'd1, 3'd6},
        '{3'd0, 3'd3, 3'd1, 3'd3},
        '{3'd0, 3'd2, 3'd2, 3'd5}
    };

    always @(posedge clk or negedge res) begin
        if (!res) ref_st <= 3'd0;
        else      ref_st <= REF_TAB[ref_st][a];
    end

    assign saida_in = force_bad ? 3'd7 : ((ref_st == 3'd7) ? 3'd3 : ref_st);
`endif

    sym_tx dut (
        .clk        (clk),
        .res        (res),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_len   (load_len),
        .load_hold  (load_hold),
        .abort      (abort),
        .a          (a),
        .a_valid    (a_valid),
        .busy       (busy),
`ifdef SYM_TX_CHECK_EN
        .saida_in   (saida_in),
        .mismatch   (mismatch),
        .err_cnt    (err_cnt),
`endif
        .done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every symbol and every done must match the head of its queue.
    always @(negedge clk) begin
        exp_t e;
        int   d;
        if (res) begin
            if (a_valid) begin
                if (exp_sym.size() == 0) begin
                    check("unexpected_symbol", exp_sym.size(), 1);
                end else begin
                    e = exp_sym.pop_front();
                    check("sym_cycle", cyc, e.cyc);
                    check("sym_value", a, e.sym);
                end
            end else begin
                check("idle_a_zero", a, 0);
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    check("unexpected_done", exp_done.size(), 1);
                end else begin
                    d = exp_done.pop_front();
                    check("done_cycle", cyc, d);
                end
            end
        end
    end

    // abort_at: 0 = none, k > 0 = abort in relative cycle k, -1 = abort together with the accept.
    task automatic send_word(input logic [17:0] data, input int len, input int hold,
                             input int abort_at, input bit garbage);
        int eff_len, eff_hold, total, base, last, k;
        logic [1:0] sym;
        logic [17:0] sh;
        @(posedge clk); #1;
        eff_len  = (len > 9) ? 9 : len;
        eff_hold = (hold == 0) ? 1 : hold;
        total    = eff_len * eff_hold;
        base     = cyc + 1;
        if (abort_at > total) abort_at = total;
        load_valid = 1'b1;
        load_data  = data;
        load_len   = 4'(len);
        load_hold  = 4'(hold);
        abort      = (abort_at < 0);
        if (abort_at >= 0) begin
            sh = data;
            for (int i = 0; i < eff_len; i++) begin
                sym = sh[17:16];
                sh  = sh << 2;
                for (int r = 0; r < eff_hold; r++) begin
                    k = i * eff_hold + r + 1;
                    if (abort_at == 0 || k <= abort_at) exp_sym.push_back('{base + k - 1, sym});
                end
            end
            if (abort_at == 0) exp_done.push_back(base + total);
        end
        @(posedge clk); #1;
        load_valid = 1'b0;
        abort      = 1'b0;
        last = (abort_at < 0) ? 0 : ((abort_at > 0) ? abort_at : total);
        for (int j = 1; j <= last; j++) begin
            abort      = (j == abort_at);
            load_valid = garbage && ($urandom_range(0, 1) == 1);
            load_data  = 18'($urandom);
            load_len   = 4'($urandom_range(1, 15));
            @(posedge clk); #1;
        end
        abort      = 1'b0;
        load_valid = 1'b0;
        if (abort_at != 0) begin
            check("after_abort_ready", load_ready, 1);
            check("after_abort_busy", busy, 0);
            check("after_abort_a", a, 0);
            check("after_abort_done", done, 0);
        end
    endtask

    initial begin
        int n;
        int ab;
        int ln, hd;
        repeat (2) @(posedge clk);
        #1;
        check("rst_a", a, 0);
        check("rst_a_valid", a_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_load_ready", load_ready, 1);
`ifdef SYM_TX_CHECK_EN
        check("rst_mismatch", mismatch, 0);
        check("rst_err_cnt", err_cnt, 0);
`endif
        res = 1'b1;

        // Basic word 2,2,0,2,2,0,3,0,1 with hold 1.
        send_word({2'd2, 2'd2, 2'd0, 2'd2, 2'd2, 2'd0, 2'd3, 2'd0, 2'd1}, 9, 1, 0, 0);
        check("basic_word_drained", exp_sym.size(), 0);
        // Hold 5 on symbols 2,0; then a hold of 0 behaving as 1.
        send_word({2'd2, 2'd0, 14'd0}, 2, 5, 0, 0);
        send_word({2'd1, 2'd3, 2'd2, 12'd0}, 3, 0, 0, 0);
        // Zero length, then a length above NSYM.
        send_word(18'h2AAAA, 0, 3, 0, 0);
        send_word(18'h1B39C, 15, 1, 0, 0);
        // Abort mid-word, abort on the last expiry, abort on the accept edge.
        send_word({2'd2, 2'd2, 2'd0, 2'd2, 2'd2, 2'd0, 2'd3, 2'd0, 2'd1}, 9, 1, 3, 0);
        send_word(18'h3C5A1, 4, 2, 8, 0);
        send_word(18'h12345, 5, 2, -1, 0);
        // Load requests during SEND must be ignored.
        send_word(18'h0F0F0, 6, 3, 0, 1);

        // Reset asserted mid-word.
        @(posedge clk); #1;
        n = cyc;
        load_valid = 1'b1;
        load_data  = {2'd3, 2'd1, 14'd0};
        load_len   = 4'd9;
        load_hold  = 4'd2;
        exp_sym.push_back('{n + 1, 2'd3});
        exp_sym.push_back('{n + 2, 2'd3});
        @(posedge clk); #1;
        load_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        res = 1'b0;
        #1;
        check("midrst_a", a, 0);
        check("midrst_a_valid", a_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_load_ready", load_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        res = 1'b1;
        send_word(18'h2D2D2, 4, 1, 0, 0);

        // Randomized words.
        for (int w = 0; w < 40; w++) begin
            ln = $urandom_range(0, 15);
            hd = $urandom_range(0, 4);
            ab = 0;
            if ($urandom_range(0, 3) == 0) ab = $urandom_range(1, 36);
            if ($urandom_range(0, 9) == 0) ab = -1;
            send_word(18'($urandom), ln, hd, ab, bit'($urandom_range(0, 1)));
        end

`ifdef SYM_TX_CHECK_EN
        check("chk_err_cnt_clean", err_cnt, 0);
        check("chk_mismatch_clean", mismatch, 0);
        @(posedge clk); #1;
        force_bad = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        force_bad = 1'b0;
        check("chk_mismatch_set", mismatch, 1);
        check("chk_err_cnt_3", err_cnt, 3);
        repeat (2) @(posedge clk);
        #1;
        check("chk_err_cnt_held", err_cnt, 3);
        check("chk_mismatch_sticky", mismatch, 1);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("sym_queue_empty", exp_sym.size(), 0);
        check("done_queue_empty", exp_done.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
